// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the memory access unit.
package mips_mem_pkg;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;

    // Big-endian byte lanes: lane 0 is the most significant byte.
    localparam logic [1:0] LANE_0 = 2'd0;  // [31:24]
    localparam logic [1:0] LANE_1 = 2'd1;  // [23:16]
    localparam logic [1:0] LANE_2 = 2'd2;  // [15:8]
    localparam logic [1:0] LANE_3 = 2'd3;  // [7:0]

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StRmwRd,
        StRmwWr,
        StResp
    } mem_state_t;

    // Memory is addressed by whole words; lane bits are dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte-lane helper: extracts/extends a load byte and inserts a store byte.
module byte_lane_unit
    import mips_mem_pkg::*;
(
    input  logic [1:0]        lane,
    input  logic              load_signed,
    input  logic [DATA_W-1:0] load_word,
    output logic [DATA_W-1:0] load_result,
    input  logic [DATA_W-1:0] store_word,
    input  logic [BYTE_W-1:0] store_byte,
    output logic [DATA_W-1:0] store_result
);

    logic [BYTE_W-1:0] lane_byte;

    // Lane select for loads and lane replace for read-modify-write stores.
    always_comb begin
        lane_byte    = '0;
        store_result = store_word;
        unique case (lane)
            LANE_0: begin
                lane_byte           = load_word[31:24];
                store_result[31:24] = store_byte;
            end
            LANE_1: begin
                lane_byte           = load_word[23:16];
                store_result[23:16] = store_byte;
            end
            LANE_2: begin
                lane_byte           = load_word[15:8];
                store_result[15:8]  = store_byte;
            end
            LANE_3: begin
                lane_byte           = load_word[7:0];
                store_result[7:0]   = store_byte;
            end
        endcase
        load_result = {{(DATA_W-BYTE_W){load_signed & lane_byte[BYTE_W-1]}}, lane_byte};
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the core and a word-wide memory_block.
// Byte stores are done as read-modify-write. Optional MISALIGN_TRAP_EN makes
// misaligned word accesses skip memory and respond with resp_err=1.
module mem_access_unit
    import mips_mem_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    output logic              mem_byteOperations
);

    mem_state_t        state_q;
    logic              write_q;
    logic              byte_q;
    logic              signed_q;
    logic              err_q;
    logic [1:0]        lane_q;
    logic [BYTE_W-1:0] byte_data_q;
    logic [DATA_W-1:0] word_q;

    logic              misaligned;
    logic [DATA_W-1:0] lane_load;
    logic [DATA_W-1:0] lane_store;
    logic [DATA_W-1:0] load_value;

    assign mem_byteOperations = 1'b0;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = !req_byte && (req_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    byte_lane_unit u_byte_lane (
        .lane         (lane_q),
        .load_signed  (signed_q),
        .load_word    (word_q),
        .load_result  (lane_load),
        .store_word   (mem_read_data),
        .store_byte   (byte_data_q),
        .store_result (lane_store)
    );

    // Response data: stores and trapped accesses return zero.
    always_comb begin
        load_value = '0;
        if (!write_q && !err_q) begin
            load_value = byte_q ? lane_load : word_q;
        end
    end

    // Access FSM with registered handshake, memory strobes and response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            req_ready      <= 1'b1;
            write_q        <= 1'b0;
            byte_q         <= 1'b0;
            signed_q       <= 1'b0;
            err_q          <= 1'b0;
            lane_q         <= '0;
            byte_data_q    <= '0;
            word_q         <= '0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_memRead    <= 1'b0;
            mem_memWrite   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        write_q     <= req_write;
                        byte_q      <= req_byte;
                        signed_q    <= req_signed;
                        lane_q      <= req_addr[1:0];
                        byte_data_q <= req_wdata[BYTE_W-1:0];
                        err_q       <= misaligned;
                        req_ready   <= 1'b0;
                        if (misaligned) begin
                            state_q <= StResp;
                        end else begin
                            mem_address <= word_align(req_addr);
                            if (!req_write) begin
                                state_q     <= StRd;
                                mem_memRead <= 1'b1;
                            end else if (req_byte) begin
                                state_q     <= StRmwRd;
                                mem_memRead <= 1'b1;
                            end else begin
                                state_q        <= StWr;
                                mem_memWrite   <= 1'b1;
                                mem_write_data <= req_wdata;
                            end
                        end
                    end
                end
                StRd: begin
                    word_q      <= mem_read_data;
                    mem_memRead <= 1'b0;
                    state_q     <= StResp;
                end
                StWr: begin
                    mem_memWrite <= 1'b0;
                    state_q      <= StResp;
                end
                StRmwRd: begin
                    // Merge the store byte into the word read this cycle.
                    mem_write_data <= lane_store;
                    mem_memRead    <= 1'b0;
                    mem_memWrite   <= 1'b1;
                    state_q        <= StRmwWr;
                end
                StRmwWr: begin
                    mem_memWrite <= 1'b0;
                    state_q      <= StResp;
                end
                StResp: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= load_value;
                    resp_err   <= err_q;
                    req_ready  <= 1'b1;
                    state_q    <= StIdle;
                end
                default: begin
                    state_q      <= StIdle;
                    req_ready    <= 1'b1;
                    mem_memRead  <= 1'b0;
                    mem_memWrite <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic        req_signed;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [17:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_memRead;
    logic        mem_memWrite;
    logic        mem_byteOperations;

    mem_access_unit dut (
        .clock              (clock),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_write          (req_write),
        .req_byte           (req_byte),
        .req_signed         (req_signed),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .resp_valid         (resp_valid),
        .resp_rdata         (resp_rdata),
        .resp_err           (resp_err),
        .mem_address        (mem_address),
        .mem_write_data     (mem_write_data),
        .mem_read_data      (mem_read_data),
        .mem_memRead        (mem_memRead),
        .mem_memWrite       (mem_memWrite),
        .mem_byteOperations (mem_byteOperations)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int resp_cnt = 0;
    int wr_cnt   = 0;
    int both_hi  = 0;

    // Word memory with combinational read; preload port used only while idle.
    logic [31:0] mem [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_idx;
    logic [31:0] pl_data;
    assign mem_read_data = mem[mem_address[17:2]];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_memWrite) begin
            mem[mem_address[17:2]] <= mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc_cyc;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [17:0] first_addr;
    logic        first_rd;
    logic        first_wr;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every resp_valid pulse.
    always @(negedge clock) begin
        if (mem_memRead && mem_memWrite) both_hi++;
        if (resp_valid === 1'b1) begin
            resp_cnt++;
            if (sb.size() == 0) begin
                check32("unexpected_resp", {31'd0, resp_valid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check32({mon_e.tag, "_rdata"}, resp_rdata, mon_e.rdata);
                check32({mon_e.tag, "_err"}, {31'd0, resp_err}, {31'd0, mon_e.err});
                check32({mon_e.tag, "_lat"}, cyc - mon_e.acc_cyc, mon_e.lat);
            end
        end
    end

    task automatic preload(input logic [15:0] idx, input logic [31:0] data);
        pl_idx  = idx;
        pl_data = data;
        pl_en   = 1'b1;
        @(posedge clock);
        #1 pl_en = 1'b0;
        @(negedge clock);
    endtask

    task automatic set_req(input logic wr, input logic byt, input logic sgn,
                           input logic [17:0] addr, input logic [31:0] wdata);
        req_write  = wr;
        req_byte   = byt;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    // Called at a negedge; issues one request and records the expected response.
    task automatic issue(input logic wr, input logic byt, input logic sgn,
                         input logic [17:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input string tag);
        int n;
        exp_t e;
        set_req(wr, byt, sgn, addr, wdata);
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check32({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        e.lat     = exp_lat;
        e.acc_cyc = cyc;
        e.tag     = tag;
        sb.push_back(e);
        @(negedge clock);
        first_addr = mem_address;
        first_rd   = mem_memRead;
        first_wr   = mem_memWrite;
    endtask

    task automatic wait_resp(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check32({tag, "_pending"}, sb.size(), 32'd0);
    endtask

    initial begin
        int busy;
        int n;
        int cnt0;
        int w0;
        exp_t e;

        reset     = 1'b1;
        req_valid = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 18'h0, 32'h0);
        repeat (2) @(negedge clock);

        // Reset state
        check32("rst_ready", {31'd0, req_ready}, 32'd1);
        check32("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check32("rst_rdata", resp_rdata, 32'd0);
        check32("rst_err", {31'd0, resp_err}, 32'd0);
        check32("rst_memread", {31'd0, mem_memRead}, 32'd0);
        check32("rst_memwrite", {31'd0, mem_memWrite}, 32'd0);
        check32("rst_addr", {14'd0, mem_address}, 32'd0);
        check32("rst_wdata", mem_write_data, 32'd0);
        check32("byteops", {31'd0, mem_byteOperations}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Word load
        preload(16'd4, 32'h12345678);
        issue(1'b0, 1'b0, 1'b0, 18'h00010, 32'h0, 32'h12345678, 1'b0, 2, "lw");
        check32("lw_addr", {14'd0, first_addr}, 32'h10);
        check32("lw_rd", {31'd0, first_rd}, 32'd1);
        wait_resp("lw");

        // Byte store via read-modify-write; upper wdata bits must be ignored
        preload(16'd4, 32'h11223344);
        issue(1'b1, 1'b1, 1'b0, 18'h00011, 32'h5A5A5AAB, 32'h0, 1'b0, 3, "sb");
        check32("sb_rmw_rd", {31'd0, first_rd}, 32'd1);
        check32("sb_rmw_addr", {14'd0, first_addr}, 32'h10);
        wait_resp("sb");
        check32("sb_mem", mem[4], 32'h11AB3344);

        // Byte loads, signed and unsigned, several lanes
        preload(16'd4, 32'h000000F0);
        issue(1'b0, 1'b1, 1'b1, 18'h00013, 32'h0, 32'hFFFFFFF0, 1'b0, 2, "lb3");
        wait_resp("lb3");
        issue(1'b0, 1'b1, 1'b0, 18'h00013, 32'h0, 32'h000000F0, 1'b0, 2, "lbu3");
        wait_resp("lbu3");
        repeat (3) @(negedge clock);
        check32("rdata_hold", resp_rdata, 32'h000000F0);

        preload(16'd5, 32'h80112233);
        issue(1'b0, 1'b1, 1'b1, 18'h00014, 32'h0, 32'hFFFFFF80, 1'b0, 2, "lb0");
        wait_resp("lb0");
        issue(1'b0, 1'b1, 1'b0, 18'h00016, 32'h0, 32'h00000022, 1'b0, 2, "lbu2");
        wait_resp("lbu2");
        issue(1'b0, 1'b1, 1'b1, 18'h00015, 32'h0, 32'h00000011, 1'b0, 2, "lb1");
        wait_resp("lb1");

        // Word store
        issue(1'b1, 1'b0, 1'b0, 18'h00020, 32'hCAFEBABE, 32'h0, 1'b0, 2, "sw");
        check32("sw_wr", {31'd0, first_wr}, 32'd1);
        check32("sw_wdata", mem_write_data, 32'hCAFEBABE);
        wait_resp("sw");
        check32("sw_mem", mem[8], 32'hCAFEBABE);

        // Request held valid through a busy byte store
        cnt0 = resp_cnt;
        set_req(1'b1, 1'b1, 1'b0, 18'h00022, 32'h00000077);
        req_valid = 1'b1;
        @(posedge clock);
        #1;
        e.rdata = 32'h0; e.err = 1'b0; e.lat = 3; e.acc_cyc = cyc; e.tag = "b2b_sb";
        sb.push_back(e);
        set_req(1'b0, 1'b0, 1'b0, 18'h00020, 32'h0);
        busy = 0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            if (!req_ready) busy++;
            n++;
        end
        check32("b2b_busy", busy, 32'd3);
        @(posedge clock);
        #1;
        e.rdata = 32'hCAFE77BE; e.err = 1'b0; e.lat = 2; e.acc_cyc = cyc; e.tag = "b2b_lw";
        sb.push_back(e);
        req_valid = 1'b0;
        wait_resp("b2b");
        repeat (4) @(negedge clock);
        check32("b2b_resp_count", resp_cnt - cnt0, 32'd2);
        check32("b2b_mem", mem[8], 32'hCAFE77BE);

        // Misaligned word store
        preload(16'd1, 32'h0);
        w0 = wr_cnt;
`ifdef MISALIGN_TRAP_EN
        issue(1'b1, 1'b0, 1'b0, 18'h00006, 32'hDEADBEEF, 32'h0, 1'b1, 1, "sw_mis");
        check32("mis_no_strobe", {31'd0, first_wr}, 32'd0);
        wait_resp("sw_mis");
        check32("mis_wr_cnt", wr_cnt - w0, 32'd0);
        check32("mis_mem", mem[1], 32'h0);
`else
        issue(1'b1, 1'b0, 1'b0, 18'h00006, 32'hDEADBEEF, 32'h0, 1'b0, 2, "sw_mis");
        check32("mis_addr", {14'd0, first_addr}, 32'h4);
        wait_resp("sw_mis");
        check32("mis_wr_cnt", wr_cnt - w0, 32'd1);
        check32("mis_mem", mem[1], 32'hDEADBEEF);
`endif

        // Reset during RMW_RD aborts the byte store
        preload(16'd4, 32'h11223344);
        cnt0 = resp_cnt;
        set_req(1'b1, 1'b1, 1'b0, 18'h00011, 32'h000000AB);
        req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clock);
        check32("abort_in_rmw_rd", {31'd0, mem_memRead}, 32'd1);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check32("abort_ready", {31'd0, req_ready}, 32'd1);
        check32("abort_memread", {31'd0, mem_memRead}, 32'd0);
        check32("abort_memwrite", {31'd0, mem_memWrite}, 32'd0);
        repeat (4) @(negedge clock);
        check32("abort_mem", mem[4], 32'h11223344);
        check32("abort_no_resp", resp_cnt - cnt0, 32'd0);

        check32("strobe_overlap", both_hi, 32'd0);
        check32("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
